// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with enable, overlap/consume modes,
// Moore or Mealy match output, and a saturating match counter with sync clear.
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FW      = $clog2(N + 1);
  localparam logic [FW-1:0]     FULL    = FW'(N);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [N-1:0]     hist_q, hist_d, nh;
  logic [FW-1:0]    fill_q, fill_d, nf;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             hit;

  generate
    if (N == 1) begin : g_nh_single
      assign nh = x;
    end else begin : g_nh_shift
      assign nh = {hist_q[N-2:0], x};
    end
  endgenerate

  // rst gates hit so the Mealy output is quiet while held in reset.
  always_comb begin
    nf  = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    hit = en & ~rst & (nh == PATTERN) & (nf == FULL);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    y_d    = hit;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      y_d    = 1'b0;
    end else if (en) begin
      hist_d = nh;
      fill_d = (hit && !OVERLAP) ? '0 : nf;
      if (hit && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
    end
  end

  assign y         = MOORE ? y_q : (hit & ~clr);
  assign match_cnt = cnt_q;
  assign cnt_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: several parameterisations share one
// input stream; each phase checks the instances relevant to it.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst, en, x, clr;
  always #5 clk = ~clk;

  logic       y0, y1, y2, y3, y4, y5;
  logic [7:0] c0, c1, c2, c3, c5;
  logic [1:0] c4;
  logic       s0, s1, s2, s3, s4, s5;

  // default: 1101, overlap, Moore
  seq_detect_param u0 (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
                       .y(y0), .match_cnt(c0), .cnt_sat(s0));
  seq_detect_param #(.OVERLAP(0)) u1 (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
                       .y(y1), .match_cnt(c1), .cnt_sat(s1));
  seq_detect_param #(.PATTERN(4'b1010), .MOORE(0)) u2 (.clk(clk), .rst(rst), .en(en), .x(x),
                       .clr(clr), .y(y2), .match_cnt(c2), .cnt_sat(s2));
  seq_detect_param #(.PATTERN(4'b1010), .MOORE(0), .OVERLAP(0)) u3 (.clk(clk), .rst(rst),
                       .en(en), .x(x), .clr(clr), .y(y3), .match_cnt(c3), .cnt_sat(s3));
  seq_detect_param #(.CNT_W(2)) u4 (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
                       .y(y4), .match_cnt(c4), .cnt_sat(s4));
  seq_detect_param #(.N(1), .PATTERN(1'b1), .MOORE(0), .OVERLAP(0)) u5 (.clk(clk),
                       .rst(rst), .en(en), .x(x), .clr(clr), .y(y5), .match_cnt(c5),
                       .cnt_sat(s5));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic e, input logic c);
    @(negedge clk);
    x = b; en = e; clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [0:18] sA  = 19'b0011011011001101110;
  logic [0:18] hA0 = 19'b0000010010000001000;
  logic [0:18] hA1 = 19'b0000010000000001000;
  logic [0:6]  sB  = 7'b1010101;
  logic [0:6]  hB2 = 7'b0001010;
  logic [0:6]  hB3 = 7'b0001000;
  logic [0:3]  s4b = 4'b1101;
  logic [0:15] sE  = 16'b1101101101101101;
  logic [0:15] hE  = 16'b0001001001001001;

  initial begin
    int r0, r1, r4;
    rst = 1'b1; en = 1'b1; x = 1'b1; clr = 1'b0;
    #2;
    chk("rst_y0", y0, 0);      chk("rst_cnt0", c0, 0);  chk("rst_sat0", s0, 0);
    chk("rst_y4", y4, 0);      chk("rst_cnt4", c4, 0);  chk("rst_sat4", s4, 0);
    chk("rst_mealy_y5", y5, 0);
    en = 1'b0;
    #1 rst = 1'b0;

    // stream A: overlap vs consume on 1101
    r0 = 0; r1 = 0;
    for (int i = 0; i < 19; i++) begin
      drive(sA[i], 1'b1, 1'b0);
      chk($sformatf("A_y5[%0d]", i), y5, sA[i]);
      tick();
      r0 += int'(hA0[i]); r1 += int'(hA1[i]);
      chk($sformatf("A_y0[%0d]", i), y0, hA0[i]);
      chk($sformatf("A_y1[%0d]", i), y1, hA1[i]);
      chk($sformatf("A_c0[%0d]", i), c0, r0);
      chk($sformatf("A_c1[%0d]", i), c1, r1);
    end
    chk("A_final_c0", c0, 3);
    chk("A_final_c1", c1, 2);
    chk("A_final_c5", c5, 11);

    drive(1'b1, 1'b1, 1'b1);
    chk("clr_mealy_y5", y5, 0);
    tick();
    chk("clr_c0", c0, 0); chk("clr_c5", c5, 0); chk("clr_y0", y0, 0);

    // stream B: Mealy 1010
    for (int i = 0; i < 7; i++) begin
      drive(sB[i], 1'b1, 1'b0);
      chk($sformatf("B_y2[%0d]", i), y2, hB2[i]);
      chk($sformatf("B_y3[%0d]", i), y3, hB3[i]);
      tick();
    end
    chk("B_c2", c2, 2);
    chk("B_c3", c3, 1);

    drive(1'b0, 1'b1, 1'b1);
    tick();

    // stream C: 1101 with idle gaps and random x while en=0
    for (int k = 0; k < 4; k++) begin
      drive(s4b[k], 1'b1, 1'b0);
      tick();
      chk($sformatf("C_y0_bit%0d", k), y0, (k == 3));
      for (int g = 0; g < 2; g++) begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk($sformatf("C_y5_gap%0d_%0d", k, g), y5, 0);
        tick();
        chk($sformatf("C_y0_gap%0d_%0d", k, g), y0, 0);
      end
    end
    chk("C_c0", c0, 1);

    // stream D: completing bit arrives with clr
    for (int k = 0; k < 3; k++) begin
      drive(s4b[k], 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("D_clr_y0", y0, 0);
    chk("D_clr_c0", c0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(s4b[k], 1'b1, 1'b0);
      tick();
      chk($sformatf("D_y0_bit%0d", k), y0, (k == 3));
    end
    chk("D_c0", c0, 1);

    drive(1'b0, 1'b1, 1'b1);
    tick();

    // stream E: saturation with CNT_W=2
    r4 = 0;
    for (int i = 0; i < 16; i++) begin
      drive(sE[i], 1'b1, 1'b0);
      tick();
      r4 += int'(hE[i]);
      chk($sformatf("E_y4[%0d]", i), y4, hE[i]);
      chk($sformatf("E_c4[%0d]", i), c4, (r4 > 3) ? 3 : r4);
      chk($sformatf("E_sat4[%0d]", i), s4, (r4 >= 3));
    end
    chk("E_c0", c0, 5);

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_y0", y0, 0); chk("arst_c0", c0, 0); chk("arst_y4", y4, 0);
    chk("arst_c4", c4, 0); chk("arst_sat4", s4, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(s4b[k], 1'b1, 1'b0);
      tick();
      chk($sformatf("R_y0_bit%0d", k), y0, (k == 3));
    end
    chk("R_c0", c0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the successor to our fixed 1101 Moore/overlap detectors. The pattern, its length, overlap mode and output style (Moore or Mealy) are parameters. An input-enable qualifies the serial bit, and a saturating match counter with synchronous clear is included. It sits on any serial bit stream in the design and replaces the per-pattern hand-coded FSMs.

## Interface
- N, default 4: pattern length in bits, legal range 1..16.
- PATTERN, default 4'b1101: N-bit pattern; PATTERN[N-1] is the first bit received.
- OVERLAP, default 1: 1 = overlapping matches allowed; 0 = bits used by a match are consumed.
- MOORE, default 1: 1 = registered output y; 0 = combinational (Mealy) y.
- CNT_W, default 8: width of the match counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  input-valid qualifier; x is sampled only on edges where en=1.
- x  in  1  serial data bit.
- clr  in  1  synchronous clear of history, fill and counter.
- y  out  1  match indication.
- match_cnt  out  CNT_W  number of matches since reset or clr, saturating.
- cnt_sat  out  1  high while match_cnt is all-ones.

## Operation
- State:
  - hist[N-1:0]: shift register of the last accepted bits, newest bit in hist[0].
  - fill: count of accepted bits since reset, clr or a consumed match, saturating at N. Width is clog2(N+1).
  - match_cnt, and y_q (used only when MOORE=1).
- Next history: nh = {hist[N-2:0], x}. When N=1, nh = x.
- Next fill: nf = min(fill+1, N).
- Match condition: hit = en & (nh == PATTERN) & (nf == N).
- On an edge with en=1 and clr=0:
  - hist ← nh.
  - If hit and OVERLAP=0, fill ← 0. Otherwise fill ← nf.
- With OVERLAP=1, a hit leaves fill at N. A match can then complete as soon as the pattern re-aligns, e.g. 1101101 gives 2 hits.
- On an edge with en=0: hist and fill hold; hit=0.
- match_cnt:
  - Increments by 1 on each hit edge.
  - Holds at 2^CNT_W−1; no wrap.
  - cnt_sat = (match_cnt == all-ones).
- clr (synchronous) has priority over everything:
  - hist ← 0, fill ← 0, match_cnt ← 0, y_q ← 0.
  - The bit presented with clr is discarded, and any hit in that cycle is not counted and not flagged.
- Output y:
  - MOORE=1: y = y_q, with y_q ← hit at each edge (0 when clr).
  - MOORE=0: y = hit & ~clr, combinational from the current en, x, clr and registered state.
- Reset values: hist=0, fill=0, match_cnt=0, cnt_sat=0, y_q=0.
  - With MOORE=0, y is also 0 during reset: hit is gated by rst.

## Timing
- MOORE=1: y rises on the edge that accepts the completing bit and stays high exactly one cycle, or longer for back-to-back hits. Latency is 1 cycle from bit presentation.
- MOORE=0: y is high during the same cycle the completing bit is presented with en=1; latency 0.
- match_cnt updates on the same edge y_q is set. It is visible one cycle after the completing bit, in both modes.
- Idle cycles (en=0) between bits do not break a partial match. With MOORE=1, y_q returns to 0 on the first en=0 edge after a hit.
- rst asserted mid-stream clears all state immediately; detection restarts from fill=0 after release.
- N=1: every accepted bit equal to PATTERN[0] is a hit, in both overlap modes.

## Test plan
- Default parameters (N=4, 1101, overlap, Moore), rst pulse, then stream 0011011011001101110 with en=1 every cycle (bit index 0 first):
  - y high in the cycles after bits 5, 8 and 15 only.
  - Final match_cnt=3.
- Same stream with OVERLAP=0: y only after bits 5 and 15; match_cnt=2.
- MOORE=0, PATTERN=4'b1010, overlap, stream 1010101: y high combinationally while bits 3 and 5 are presented; match_cnt=2. With OVERLAP=0 only bit 3 hits; match_cnt=1.
- Default parameters, stream 1,1,0,1 with en=0 cycles inserted between each bit (x toggling randomly while en=0): exactly one hit, on the accepting edge of the final 1.
- Present the completing bit of 1101 together with clr=1: no y, match_cnt=0, fill=0. A following 1,1,0,1 produces a hit only on its 4th bit.
- CNT_W=2, stream with 5 overlapping matches: match_cnt reads 1,2,3,3,3; cnt_sat goes high after the 3rd match. Asserting rst mid-pattern zeroes all outputs asynchronously.
